bloom_bram_rmw_ctrl: RTL and testbench
======================================

Name: bloom_bram_rmw_ctrl

Overview:
- Initiator side of the bloom-filter extern's true-dual-port, read-first BRAM: converts bit-level query/insert requests into word read-modify-write cycles on the two BRAM ports.
- Port 1 reads; port 2 writes. The BRAM has 2-cycle read latency (en, then regce).
- Also owns filter clearing: a hardware sweep that zeroes every word after reset and on request.

Parameters:
- L2_DEPTH, 8, log2 of BRAM word count; must match the attached BRAM.
- WIDTH, 32, BRAM word width; power of two, at least 2.
- IDX_W, L2_DEPTH+log2(WIDTH), derived localparam; bit-index width.

Ports:
- clk  in  1  sole clock, shared with the BRAM
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_op  in  1  0=query, 1=insert
- req_idx  in  IDX_W  bit index; upper L2_DEPTH bits = word address, lower bits = bit-in-word
- resp_valid  out  1  one-cycle result strobe; no backpressure
- resp_hit  out  1  addressed bit was 1 before this op
- clear_req  in  1  start a clear sweep (level, sampled in RUN)
- clear_busy  out  1  drain or sweep in progress
- bram_en1, bram_we1, bram_rst1, bram_regce1  out  1 each  BRAM port-1 controls
- bram_addr1  out  L2_DEPTH; bram_din1  out  WIDTH; bram_dout1  in  WIDTH
- bram_en2, bram_we2, bram_rst2, bram_regce2  out  1 each  BRAM port-2 controls
- bram_addr2  out  L2_DEPTH; bram_din2  out  WIDTH; bram_dout2  in  WIDTH (unused)

Behaviour:
- Reset values:
  - req_ready=0, resp_valid=0, resp_hit=0, clear_busy=1.
  - All BRAM enables and write enables 0; bram_rst1/2=0; addresses and data 0.
  - State=CLEAR with sweep counter 0.
  - Reset does not alter BRAM contents, so every reset is followed by a full sweep.
- FSM: CLEAR, RUN, DRAIN.
  - CLEAR: in_flight forced 0. Per cycle: bram_en2=bram_we2=1, bram_addr2=counter, bram_din2=0, counter++. Write-history entries are invalidated.
  - CLEAR exit: after writing address DEPTH-1, go to RUN next cycle. Duration is exactly DEPTH cycles.
  - RUN: req_ready=1 and clear_busy=0, combinationally from state.
  - RUN -> DRAIN: on clear_req=1. A request in the same cycle is still accepted; clear_req wins for subsequent cycles. req_ready=0 from DRAIN onward.
  - DRAIN: wait until all three pipeline stages are empty, then go to CLEAR with counter 0.
- Pipeline, request accepted in cycle n:
  - Cycle n: bram_en1=1, bram_addr1=word addr (combinational from req). Stage-1 register captures addr, bit, op.
  - Cycle n+1: bram_regce1=1 for the stage-1 entry.
  - Cycle n+2: base word is forwarded or bram_dout1. hit=base[bit].
    - Insert: bram_en2=bram_we2=1, bram_addr2=addr, bram_din2=base | (1<<bit). The write occurs even if the bit is already set.
    - Query: no write.
  - Cycle n+3: resp_valid=1 with resp_hit.
  - Fixed latency 3; throughput one request per cycle.
- Hazard forwarding:
  - A write committed at the end of cycle m is invisible to reads issued in m-1 and m.
  - Keep a 2-entry write history: h0 = write of previous cycle, h1 = write two cycles ago, each with valid, addr, data.
  - At stage 2, base selection priority: h0 match, then h1 match, then bram_dout1.
  - This makes back-to-back inserts to the same word accumulate bits.
- Unused BRAM port controls are 0: bram_en1 when idle, bram_regce2, bram_rst1, bram_rst2.
- Reset mid-operation: in-flight requests are dropped and no resp_valid is issued. The sweep then restores an empty filter.

Decomposition:
- Package bloom_bram_pkg: op encoding (OP_QUERY=0, OP_INSERT=1), FSM state enum, a clog2 function, the IDX_W derivation, and a pipeline-entry struct {valid, op, addr, bit}.
- Sub-module bloom_fwd_hist: the 2-entry write history and priority match. Inputs: write valid/addr/data and lookup addr. Output: forwarded word and select.
- The BRAM itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then observe: clear_busy stays high for exactly 256 cycles, bram_addr2 sweeps 0..255 with din2=0 and we2=1, then req_ready=1.
- Query idx 0x123 on an empty filter -> resp_valid 3 cycles later, hit=0, no port-2 write. Insert 0x123 -> hit=0, write addr 0x09, din2=0x0000_0008. Query again -> hit=1.
- Back-to-back inserts in consecutive cycles to idx 0x40, 0x41, 0x42 (same word 0x02) -> successive din2 = 0x1, 0x3, 0x7. Final query hit=1 for each index.
- Inserts two cycles apart to the same word (h1 path), plus a different-word insert in between -> no lost bits and no cross-address forwarding.
- After inserting 0x123, assert clear_req during a 3-deep stream -> all 3 responses are delivered, DRAIN precedes the 256-cycle sweep, and a later query of 0x123 returns hit=0.
- Assert rst mid-stream with 2 requests in flight -> no resp_valid for them, outputs take reset values immediately (async), and the sweep restarts from address 0.

Source files
------------

// File: rtl/bloom_bram_pkg.sv
// Shared types and helpers for the bloom-filter BRAM read-modify-write controller.
package bloom_bram_pkg;

    localparam logic OP_QUERY  = 1'b0;
    localparam logic OP_INSERT = 1'b1;

    // Pipeline entries carry addr/bit at a fixed maximum width so the struct
    // can live in the package; users slice out the configured widths.
    localparam int unsigned PIPE_ADDR_W = 24;
    localparam int unsigned PIPE_BIT_W  = 8;

    typedef enum logic [1:0] {
        StClear = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    typedef struct packed {
        logic                   valid;
        logic                   op;
        logic [PIPE_ADDR_W-1:0] addr;
        logic [PIPE_BIT_W-1:0]  bit_pos;
    } pipe_entry_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    function automatic int unsigned idx_width(input int unsigned l2_depth,
                                              input int unsigned width);
        return l2_depth + clog2(width);
    endfunction

endpackage

// File: rtl/bloom_fwd_hist.sv
// Two-entry history of recent port-2 writes. Covers the window in which a
// committed write is not yet visible on the read port; h0 (newest) wins.
module bloom_fwd_hist
    import bloom_bram_pkg::*;
#(
    parameter int unsigned L2_DEPTH = 8,
    parameter int unsigned WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wr_valid,
    input  logic [L2_DEPTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [L2_DEPTH-1:0] lk_addr,
    output logic                fwd_sel,
    output logic [WIDTH-1:0]    fwd_data
);

    logic                h0_valid_q, h1_valid_q;
    logic [L2_DEPTH-1:0] h0_addr_q, h1_addr_q;
    logic [WIDTH-1:0]    h0_data_q, h1_data_q;

    // Shift the newest write into h0, ageing h0 into h1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h0_valid_q <= 1'b0;
            h1_valid_q <= 1'b0;
            h0_addr_q  <= '0;
            h1_addr_q  <= '0;
            h0_data_q  <= '0;
            h1_data_q  <= '0;
        end else if (flush) begin
            h0_valid_q <= 1'b0;
            h1_valid_q <= 1'b0;
        end else begin
            h0_valid_q <= wr_valid;
            h0_addr_q  <= wr_addr;
            h0_data_q  <= wr_data;
            h1_valid_q <= h0_valid_q;
            h1_addr_q  <= h0_addr_q;
            h1_data_q  <= h0_data_q;
        end
    end

    // Priority match: the newer write holds the more complete word.
    always_comb begin
        fwd_sel  = 1'b0;
        fwd_data = '0;
        if (h0_valid_q && (h0_addr_q == lk_addr)) begin
            fwd_sel  = 1'b1;
            fwd_data = h0_data_q;
        end else if (h1_valid_q && (h1_addr_q == lk_addr)) begin
            fwd_sel  = 1'b1;
            fwd_data = h1_data_q;
        end
    end

endmodule

// File: rtl/bloom_bram_rmw_ctrl.sv
// Bloom-filter BRAM initiator: turns bit query/insert requests into word
// read-modify-write cycles (port 1 reads, port 2 writes) and sweeps the
// array to zero after reset and on clear request.
module bloom_bram_rmw_ctrl
    import bloom_bram_pkg::*;
#(
    parameter int unsigned L2_DEPTH = 8,
    parameter int unsigned WIDTH    = 32,
    localparam int unsigned IDX_W   = L2_DEPTH + clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [IDX_W-1:0]    req_idx,
    output logic                resp_valid,
    output logic                resp_hit,
    input  logic                clear_req,
    output logic                clear_busy,
    output logic                bram_en1,
    output logic                bram_we1,
    output logic                bram_rst1,
    output logic                bram_regce1,
    output logic [L2_DEPTH-1:0] bram_addr1,
    output logic [WIDTH-1:0]    bram_din1,
    input  logic [WIDTH-1:0]    bram_dout1,
    output logic                bram_en2,
    output logic                bram_we2,
    output logic                bram_rst2,
    output logic                bram_regce2,
    output logic [L2_DEPTH-1:0] bram_addr2,
    output logic [WIDTH-1:0]    bram_din2,
    input  logic [WIDTH-1:0]    bram_dout2
);

    localparam int unsigned BIT_W = clog2(WIDTH);

    state_e              state_q, state_d;
    logic [L2_DEPTH-1:0] cnt_q, cnt_d;
    pipe_entry_t         s1_q, s1_d, s2_q, s2_d;
    logic                resp_valid_q, resp_hit_q;

    logic                accept;
    logic [L2_DEPTH-1:0] req_addr;
    logic [BIT_W-1:0]    req_bit;
    logic [L2_DEPTH-1:0] s2_addr;
    logic [BIT_W-1:0]    s2_bit;
    logic                s2_write;
    logic                s2_hit;
    logic                fwd_sel;
    logic [WIDTH-1:0]    fwd_data;
    logic [WIDTH-1:0]    base_word;
    logic [WIDTH-1:0]    ins_word;

    assign req_addr = req_idx[IDX_W-1:BIT_W];
    assign req_bit  = req_idx[BIT_W-1:0];
    assign s2_addr  = s2_q.addr[L2_DEPTH-1:0];
    assign s2_bit   = s2_q.bit_pos[BIT_W-1:0];

    assign req_ready  = (state_q == StRun);
    assign clear_busy = (state_q != StRun);
    assign accept     = req_ready && req_valid;

    // Next state: sweep DEPTH words, run, then drain the pipe before sweeping again.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = StRun;
            end
            StRun: begin
                if (clear_req) state_d = StDrain;
            end
            StDrain: begin
                if (!s1_q.valid && !s2_q.valid && !resp_valid_q) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    // Pipeline advance; nothing is in flight while sweeping.
    always_comb begin
        s1_d = '0;
        if (accept) begin
            s1_d.valid   = 1'b1;
            s1_d.op      = req_op;
            s1_d.addr    = PIPE_ADDR_W'(req_addr);
            s1_d.bit_pos = PIPE_BIT_W'(req_bit);
        end
        s2_d = s1_q;
        if (state_q == StClear) s2_d = '0;
    end

    // State, sweep counter, pipeline and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StClear;
            cnt_q        <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            resp_valid_q <= s2_q.valid;
            resp_hit_q   <= s2_q.valid && s2_hit;
        end
    end

    bloom_fwd_hist #(
        .L2_DEPTH (L2_DEPTH),
        .WIDTH    (WIDTH)
    ) u_fwd_hist (
        .clk      (clk),
        .rst      (rst),
        .flush    (state_q == StClear),
        .wr_valid (s2_write),
        .wr_addr  (s2_addr),
        .wr_data  (ins_word),
        .lk_addr  (s2_addr),
        .fwd_sel  (fwd_sel),
        .fwd_data (fwd_data)
    );

    // Stage 2: pick the freshest copy of the word and merge the new bit.
    always_comb begin
        base_word = fwd_sel ? fwd_data : bram_dout1;
        s2_hit    = base_word[s2_bit];
        ins_word  = base_word | (WIDTH'(1) << s2_bit);
        s2_write  = s2_q.valid && (s2_q.op == OP_INSERT);
    end

    // BRAM port drive; rst gates port 2 because the reset state is the sweep.
    always_comb begin
        bram_en1    = accept;
        bram_we1    = 1'b0;
        bram_rst1   = 1'b0;
        bram_regce1 = s1_q.valid;
        bram_addr1  = accept ? req_addr : '0;
        bram_din1   = '0;
        bram_en2    = 1'b0;
        bram_we2    = 1'b0;
        bram_rst2   = 1'b0;
        bram_regce2 = 1'b0;
        bram_addr2  = '0;
        bram_din2   = '0;
        if (rst) begin
            bram_en2 = 1'b0;
        end else if (state_q == StClear) begin
            bram_en2   = 1'b1;
            bram_we2   = 1'b1;
            bram_addr2 = cnt_q;
        end else if (s2_write) begin
            bram_en2   = 1'b1;
            bram_we2   = 1'b1;
            bram_addr2 = s2_addr;
            bram_din2  = ins_word;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;

    logic unused_sig;
    assign unused_sig = ^{bram_dout2, s2_q.addr[PIPE_ADDR_W-1:L2_DEPTH],
                          s2_q.bit_pos[PIPE_BIT_W-1:BIT_W]};

endmodule

// File: tb/tb_bloom_bram_rmw_ctrl.sv
// Scoreboard bench for bloom_bram_rmw_ctrl with a behavioural read-first BRAM.
module tb_bloom_bram_rmw_ctrl;

    localparam int unsigned L2_DEPTH = 8;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned BIT_W    = 5;
    localparam int unsigned IDX_W    = 13;
    localparam int unsigned DEPTH    = 256;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid, req_ready, req_op;
    logic [IDX_W-1:0]    req_idx;
    logic                resp_valid, resp_hit, clear_req, clear_busy;
    logic                bram_en1, bram_we1, bram_rst1, bram_regce1;
    logic [L2_DEPTH-1:0] bram_addr1;
    logic [WIDTH-1:0]    bram_din1, bram_dout1;
    logic                bram_en2, bram_we2, bram_rst2, bram_regce2;
    logic [L2_DEPTH-1:0] bram_addr2;
    logic [WIDTH-1:0]    bram_din2, bram_dout2;

    always #5 clk = ~clk;

    bloom_bram_rmw_ctrl #(
        .L2_DEPTH (L2_DEPTH),
        .WIDTH    (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_idx     (req_idx),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .bram_en1    (bram_en1),
        .bram_we1    (bram_we1),
        .bram_rst1   (bram_rst1),
        .bram_regce1 (bram_regce1),
        .bram_addr1  (bram_addr1),
        .bram_din1   (bram_din1),
        .bram_dout1  (bram_dout1),
        .bram_en2    (bram_en2),
        .bram_we2    (bram_we2),
        .bram_rst2   (bram_rst2),
        .bram_regce2 (bram_regce2),
        .bram_addr2  (bram_addr2),
        .bram_din2   (bram_din2),
        .bram_dout2  (bram_dout2)
    );

    // Read-first true-dual-port BRAM, 2-cycle read latency (en, then regce).
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] lat1, lat2, dout1_r, dout2_r;
    always @(posedge clk) begin
        if (bram_en1) lat1 <= mem[bram_addr1];
        if (bram_regce1) dout1_r <= lat1;
        if (bram_en2) lat2 <= mem[bram_addr2];
        if (bram_regce2) dout2_r <= lat2;
        if (bram_en2 && bram_we2) mem[bram_addr2] <= bram_din2;
    end
    assign bram_dout1 = dout1_r;
    assign bram_dout2 = dout2_r;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the filter as a flat bit array.
    bit model [DEPTH*WIDTH];

    typedef struct {
        int   due;
        logic hit;
    } resp_t;
    typedef struct {
        int                  due;
        logic [L2_DEPTH-1:0] addr;
        logic [WIDTH-1:0]    data;
    } wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        foreach (model[i]) model[i] = 1'b0;
    endtask

    task automatic push_request(input logic op, input logic [IDX_W-1:0] idx);
        resp_t r;
        wr_t   w;
        int    word;
        word  = int'(idx) / WIDTH;
        r.due = cyc + 3;
        r.hit = model[idx];
        resp_q.push_back(r);
        if (op) begin
            model[idx] = 1'b1;
            w.due  = cyc + 2;
            w.addr = L2_DEPTH'(word);
            for (int j = 0; j < WIDTH; j++) w.data[j] = model[word*WIDTH + j];
            wr_q.push_back(w);
        end
    endtask

    // Monitor: pop/compare DUT outputs, record newly accepted requests.
    always @(negedge clk) begin
        resp_t r;
        wr_t   w;
        if (!rst) begin
            if (resp_q.size() > 0 && resp_q[0].due < cyc) begin
                r = resp_q.pop_front();
                check("resp_missing", 64'(cyc), 64'(r.due));
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_cycle", 64'(cyc), 64'(r.due));
                    check("resp_hit", resp_hit, r.hit);
                end
            end
            // Sweep writes carry zero data; any other write is an insert.
            if (bram_en2 && bram_we2 && bram_din2 != '0) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", {bram_addr2, bram_din2}, 0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(w.due));
                    check("wr_addr", bram_addr2, w.addr);
                    check("wr_data", bram_din2, w.data);
                end
            end
            if (req_valid && req_ready) push_request(req_op, req_idx);
            if (clear_req && req_ready) model_clear();
        end
    end

    task automatic drive(input logic v, input logic op, input logic [IDX_W-1:0] idx,
                         input logic clr);
        @(posedge clk);
        #1;
        req_valid = v;
        req_op    = op;
        req_idx   = idx;
        clear_req = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Caller is at the negedge showing sweep word 0.
    task automatic check_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            check("sweep", {clear_busy, req_ready, bram_en2, bram_we2, bram_addr2, bram_din2},
                  {1'b1, 1'b0, 1'b1, 1'b1, 8'(i), 32'h0});
            @(negedge clk);
        end
        check("post_sweep", {clear_busy, req_ready}, 2'b01);
    endtask

    task automatic check_reset_outputs();
        check("rst_ctrl", {req_ready, resp_valid, resp_hit, clear_busy}, 4'b0001);
        check("rst_bram_ctl", {bram_en1, bram_we1, bram_rst1, bram_regce1,
                               bram_en2, bram_we2, bram_rst2, bram_regce2}, 8'h00);
        check("rst_bram_bus", {bram_addr1, bram_din1, bram_addr2, bram_din2}, 0);
    endtask

    localparam logic Q = 1'b0;
    localparam logic I = 1'b1;

    initial begin
        int  wait_n;
        logic [IDX_W-1:0] ridx;
        req_valid = 0;
        req_op    = 0;
        req_idx   = '0;
        clear_req = 0;
        model_clear();

        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_sweep();

        // Single query/insert/query on word 0x09, bit 3.
        drive(1, Q, 13'h123, 0); idle(5);
        drive(1, I, 13'h123, 0); idle(5);
        drive(1, Q, 13'h123, 0); idle(5);

        // Back-to-back inserts into one word (h0 path).
        drive(1, I, 13'h040, 0);
        drive(1, I, 13'h041, 0);
        drive(1, I, 13'h042, 0);
        drive(1, Q, 13'h040, 0);
        drive(1, Q, 13'h041, 0);
        drive(1, Q, 13'h042, 0);
        idle(5);

        // Same word two cycles apart with a different word between (h1 path).
        drive(1, I, 13'h060, 0);
        drive(1, I, 13'h085, 0);
        drive(1, I, 13'h062, 0);
        drive(1, Q, 13'h061, 0);
        drive(1, Q, 13'h060, 0);
        drive(1, Q, 13'h062, 0);
        drive(1, Q, 13'h085, 0);
        idle(5);

        // Clear during a 3-deep stream.
        drive(1, Q, 13'h123, 0);
        drive(1, I, 13'h200, 0);
        drive(1, Q, 13'h040, 1);
        drive(0, Q, '0, 0);
        @(negedge clk);
        check("drain_busy", {clear_busy, req_ready}, 2'b10);
        wait_n = 0;
        while (!(bram_en2 && bram_we2 && bram_din2 == '0) && wait_n < 16) begin
            @(negedge clk);
            wait_n++;
        end
        check("sweep_start_seen", wait_n < 16, 1);
        check("drained_before_sweep", 64'(resp_q.size() + wr_q.size()), 0);
        check_sweep();
        drive(1, Q, 13'h123, 0);
        drive(1, Q, 13'h200, 0);
        idle(5);

        // Randomised traffic concentrated on a few words to provoke hazards.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0) ridx = IDX_W'({$urandom_range(0, 7), 5'($urandom)});
            else ridx = IDX_W'($urandom);
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom), ridx, 0);
        end
        idle(6);

        // Reset with two requests in flight.
        drive(1, I, 13'h300, 0);
        drive(1, I, 13'h301, 0);
        @(posedge clk);
        #3;
        rst       = 1'b1;
        req_valid = 1'b0;
        resp_q.delete();
        wr_q.delete();
        model_clear();
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_sweep();
        drive(1, Q, 13'h300, 0);
        drive(1, Q, 13'h301, 0);
        idle(8);

        check("resp_queue_empty", 64'(resp_q.size()), 0);
        check("wr_queue_empty", 64'(wr_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
